// File: rtl/smg_pkg.sv
// smg_pkg: shared definitions for the multiplexed seven-segment driver.
//   state_t     conversion FSM states (IDLE / SHIFT / COMMIT)
//   SEG_DIGIT   segment patterns {g,f,e,d,c,b,a} for decimal digits 0..9
//   SEG_DASH    pattern shown on every digit when the value overflows
//   SEG_OFF     all segments dark
//   seg_decode  BCD nibble to segment pattern (non-decimal nibbles go dark)
//   pow10       10**n, used to size the overflow limit
package smg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_DIGIT[0];
         4'd1:    s = SEG_DIGIT[1];
         4'd2:    s = SEG_DIGIT[2];
         4'd3:    s = SEG_DIGIT[3];
         4'd4:    s = SEG_DIGIT[4];
         4'd5:    s = SEG_DIGIT[5];
         4'd6:    s = SEG_DIGIT[6];
         4'd7:    s = SEG_DIGIT[7];
         4'd8:    s = SEG_DIGIT[8];
         4'd9:    s = SEG_DIGIT[9];
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/smg_scan_if.sv
// smg_scan_if: value/control and display bus of the seven-segment driver.
//   bin_in, load        value to display and its one-cycle convert request
//   dp_mask, blank_lz   per-digit decimal points, leading-zero blanking
//   busy, overflow      conversion status, committed value out of range
//   smg_en, seg         one-hot digit enable and {dp,g,f,e,d,c,b,a}
// master = the side issuing values (user logic / bench), slave = smg_scan.
interface smg_scan_if #(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned BIN_W    = 14
) ();

   logic [BIN_W-1:0]    bin_in;
   logic                load;
   logic [N_DIGITS-1:0] dp_mask;
   logic                blank_lz;
   logic                busy;
   logic                overflow;
   logic [N_DIGITS-1:0] smg_en;
   logic [7:0]          seg;

   modport master (
      output bin_in, load, dp_mask, blank_lz,
      input  busy, overflow, smg_en, seg
   );

   modport slave (
      input  bin_in, load, dp_mask, blank_lz,
      output busy, overflow, smg_en, seg
   );

endinterface

// File: rtl/smg_bin2bcd.sv
// smg_bin2bcd: sequential double-dabble binary to BCD converter.
//   clk_50M, rst_n  clock, synchronous active-low reset
//   start           accepted only in IDLE; captures bin
//   bin             binary value
//   busy            high from the accepting edge until COMMIT completes
//   done            one-cycle pulse when bcd/ovf are refreshed
//   bcd             4*N_DIGITS BCD result, registered
//   ovf             value does not fit in N_DIGITS decimal digits
module smg_bin2bcd
   import smg_pkg::*;
#(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned BIN_W    = 14
) (
   input  logic                  clk_50M,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic                  ovf
);

   localparam int unsigned     BCD_W = 4 * N_DIGITS;
   localparam int unsigned     SR_W  = BCD_W + BIN_W;
   localparam int unsigned     CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam longint unsigned LIMIT = pow10(N_DIGITS);

   state_t           state;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_adj;
   logic [BIN_W-1:0] cap;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             cap_big;

   // Add-3 on every BCD nibble >= 5 before the shift.
   always_comb begin
      sr_adj = sr;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
            sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
         end
      end
   end

   assign cap_big = (64'(cap) >= LIMIT);

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cap   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr    <= {{BCD_W{1'b0}}, bin};
                  cap   <= bin;
                  cnt   <= '0;
                  carry <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr    <= {sr_adj[SR_W-2:0], 1'b0};
               // Bit leaving the top nibble means the value needs another digit.
               carry <= carry | sr_adj[SR_W-1];
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               bcd   <= sr[SR_W-1 -: BCD_W];
               ovf   <= carry | cap_big;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/smg_scan.sv
// smg_scan: multiplexed seven-segment display driver.
//   clk_50M, rst_n  system clock, synchronous active-low reset
//   bus (slave)     bin_in/load request a conversion; dp_mask/blank_lz are
//                   sampled live; busy/overflow report conversion state;
//                   smg_en (digit k on bit N_DIGITS-1-k) and seg drive the board.
// A tick divider advances the scan index every CLK_HZ/SCAN_HZ cycles; the
// display registers change only when a conversion commits.
module smg_scan
   import smg_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned BIN_W       = 14,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned SCAN_HZ     = 1_000,
   parameter bit          SEG_ACT_LOW = 1'b0
) (
   input logic        clk_50M,
   input logic        rst_n,
   smg_scan_if.slave  bus
);

   localparam int unsigned         DIV    = CLK_HZ / SCAN_HZ;
   localparam int unsigned         CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned         IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [N_DIGITS-1:0] INV_EN  = {N_DIGITS{SEG_ACT_LOW}};
   localparam logic [7:0]          INV_SEG = {8{SEG_ACT_LOW}};

   logic                  start;
   logic                  bcd_busy;
   logic                  bcd_done;
   logic                  bcd_ovf;
   logic [4*N_DIGITS-1:0] bcd;

   logic                  busy_q;
   logic                  ovf_q;
   logic [4*N_DIGITS-1:0] disp;

   logic [CNT_W-1:0]      cnt;
   logic                  tick;
   logic [IDX_W-1:0]      idx;

   logic                  zacc;
   logic [N_DIGITS-1:0]   zero_above;
   logic [3:0]            digit;
   logic                  dp_bit;
   logic                  slot_zero;
   logic                  blank;
   logic [N_DIGITS-1:0]   en_sel;
   logic [N_DIGITS-1:0]   en_n;
   logic [7:0]            seg_n;
   logic [N_DIGITS-1:0]   en_q;
   logic [7:0]            seg_q;

   // The converter also ignores start outside IDLE; gating with busy_q keeps
   // the request dropped for the whole externally visible busy window.
   assign start = bus.load & ~busy_q;

   smg_bin2bcd #(
      .N_DIGITS (N_DIGITS),
      .BIN_W    (BIN_W)
   ) u_bin2bcd (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .start   (start),
      .bin     (bus.bin_in),
      .busy    (bcd_busy),
      .done    (bcd_done),
      .bcd     (bcd),
      .ovf     (bcd_ovf)
   );

   // Status and digit registers; digits and overflow change together.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
         disp   <= '0;
      end else begin
         busy_q <= bcd_busy;
         if (bcd_done) begin
            disp  <= bcd;
            ovf_q <= bcd_ovf;
         end
      end
   end

   assign tick = (cnt == CNT_W'(DIV - 1));

   always_comb begin
      zacc       = 1'b1;
      zero_above = '0;
      digit      = '0;
      dp_bit     = 1'b0;
      slot_zero  = 1'b0;
      en_sel     = '0;
      en_n       = '0;
      seg_n      = '0;
      // zero_above[k]: digit k and every digit above it are zero.
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         zacc = zacc & (disp[4*(N_DIGITS-1-i) +: 4] == 4'd0);
         zero_above[N_DIGITS-1-i] = zacc;
      end
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            digit                = disp[4*i +: 4];
            dp_bit               = bus.dp_mask[i];
            slot_zero            = zero_above[i];
            en_sel[N_DIGITS-1-i] = 1'b1;
         end
      end
      blank = bus.blank_lz & ~ovf_q & (idx != '0) & slot_zero;
      if (!blank) begin
         en_n  = en_sel;
         seg_n = {dp_bit, ovf_q ? SEG_DASH : seg_decode(digit)};
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= '0;
         en_q  <= INV_EN;
         seg_q <= INV_SEG;
      end else begin
         if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         // Load the output flops once per slot (first cycle of the new idx),
         // so a commit can only ever appear from the start of a slot.
         if (cnt == '0) begin
            en_q  <= en_n ^ INV_EN;
            seg_q <= seg_n ^ INV_SEG;
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;
   assign bus.smg_en   = en_q;
   assign bus.seg      = seg_q;

endmodule
